// File: rtl/switch_conditioner.sv
// Slide-switch front end: synchronise, debounce and edge-detect four switches,
// then hand one prioritised command at a time to the vacuum FSM.
module sw_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic raw,
  output logic level
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (ena) begin
        if (s2 == level) begin
          cnt <= '0;
        end else if (cnt == LAST) begin
          level <= s2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

module switch_conditioner #(
  parameter int N_SW = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  input  logic [N_SW-1:0] sw_raw,
  output logic [N_SW-1:0] sw_level,
  output logic [N_SW-1:0] sw_rise,
  output logic [1:0]      cmd,
  output logic            cmd_valid,
  input  logic            cmd_ready,
  output logic            cmd_dropped
);

  localparam logic [1:0] C_OFF   = 2'b00;
  localparam logic [1:0] C_ON    = 2'b01;
  localparam logic [1:0] C_CLEAN = 2'b10;
  localparam logic [1:0] C_EVADE = 2'b11;

  typedef enum logic {
    IDLE,
    PEND
  } state_t;

  state_t          state;
  logic [N_SW-1:0] level_d;
  logic [N_SW-1:0] win_oh;
  logic [1:0]      win_code;
  logic            any_rise;
  logic            lose;

  for (genvar i = 0; i < N_SW; i++) begin : g_db
    sw_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .clk  (clk),
      .rst_n(rst_n),
      .ena  (ena),
      .raw  (sw_raw[i]),
      .level(sw_level[i])
    );
  end

  assign sw_rise  = ena ? (sw_level & ~level_d) : '0;
  assign any_rise = |sw_rise;

  // Mask lower-priority rises so the decoder sees at most one hot bit.
  always_comb begin
    win_oh    = '0;
    win_oh[0] = sw_rise[0];
    win_oh[3] = sw_rise[3] & ~sw_rise[0];
    win_oh[2] = sw_rise[2] & ~sw_rise[0] & ~sw_rise[3];
    win_oh[1] = sw_rise[1] & ~sw_rise[0] & ~sw_rise[3]
              & ~sw_rise[2];
  end

  always_comb begin
    win_code = C_OFF;
    unique case (1'b1)
      win_oh[0]: win_code = C_OFF;
      win_oh[3]: win_code = C_EVADE;
      win_oh[2]: win_code = C_CLEAN;
      win_oh[1]: win_code = C_ON;
      default:   win_code = C_OFF;
    endcase
  end

  assign lose = |(sw_rise & ~win_oh);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      level_d     <= '0;
      cmd         <= C_OFF;
      cmd_valid   <= 1'b0;
      cmd_dropped <= 1'b0;
    end else begin
      level_d <= sw_level;
      if (lose) cmd_dropped <= 1'b1;
      case (state)
        IDLE: begin
          if (any_rise) begin
            cmd       <= win_code;
            cmd_valid <= 1'b1;
            state     <= PEND;
          end
        end
        PEND: begin
          if (cmd_ready) begin
            if (any_rise) begin
              cmd <= win_code;
            end else begin
              cmd_valid <= 1'b0;
              state     <= IDLE;
            end
          end else if (any_rise) begin
            // Pending command keeps its slot unless POWER_OFF must preempt it.
            cmd_dropped <= 1'b1;
            if (win_oh[0] && cmd != C_OFF) cmd <= C_OFF;
          end
        end
        default: begin
          state     <= IDLE;
          cmd_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_switch_conditioner.sv
// Bench for switch_conditioner with a short debounce window.
// Transfers are scored against a queue of expected commands.
module tb_switch_conditioner;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [3:0] sw_raw;
  logic [3:0] sw_level;
  logic [3:0] sw_rise;
  logic [1:0] cmd;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_dropped;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];
  logic [1:0] e;

  typedef struct {
    int         idx;
    logic [1:0] exp_cmd;
    int         exp_lat;
  } vec_t;
  vec_t vecs[4];

  switch_conditioner #(
    .N_SW(4),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .sw_raw     (sw_raw),
    .sw_level   (sw_level),
    .sw_rise    (sw_rise),
    .cmd        (cmd),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_dropped(cmd_dropped)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  // Handshake is stable between negedge and the next posedge.
  always @(negedge clk) begin
    if (rst_n && cmd_valid && cmd_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL xfer: unexpected cmd %0d", cmd);
      end else begin
        e = exp_q.pop_front();
        if (cmd !== e) begin
          errors++;
          $display("FAIL xfer: got cmd %0d want %0d", cmd, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    ena       = 1'b1;
    sw_raw    = '0;
    cmd_ready = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (n < 20) begin
      step(1);
      n++;
      if (cmd_valid) break;
    end
  endtask

  initial begin
    int n;
    int cnt;
    bit ok;

    vecs[0] = '{idx: 1, exp_cmd: 2'b01, exp_lat: DB + 3};
    vecs[1] = '{idx: 2, exp_cmd: 2'b10, exp_lat: DB + 3};
    vecs[2] = '{idx: 3, exp_cmd: 2'b11, exp_lat: DB + 3};
    vecs[3] = '{idx: 0, exp_cmd: 2'b00, exp_lat: DB + 3};

    do_reset();
    chk("reset", {sw_level, sw_rise, cmd, cmd_valid, cmd_dropped}, 0);

    // 1: single ON, held until ready
    exp_q.push_back(2'b01);
    sw_raw[1] = 1'b1;
    step(DB + 1);
    chk("t1 level early", sw_level, 4'b0000);
    step(1);
    chk("t1 level", sw_level, 4'b0010);
    chk("t1 rise", sw_rise, 4'b0010);
    chk("t1 valid early", cmd_valid, 0);
    step(1);
    chk("t1 rise once", sw_rise, 4'b0000);
    chk("t1 valid", cmd_valid, 1);
    chk("t1 cmd", cmd, 2'b01);
    step(3);
    chk("t1 held", {cmd_valid, cmd}, 3'b101);
    cmd_ready = 1'b1;
    step(1);
    cmd_ready = 1'b0;
    chk("t1 taken", cmd_valid, 0);
    sw_raw = '0;
    step(8);
    chk("t1 fall", {sw_level, cmd_valid, cmd_dropped}, 0);

    // 2: short glitch is filtered
    sw_raw[2] = 1'b1;
    step(DB - 1);
    sw_raw[2] = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (sw_level != 0 || sw_rise != 0 || cmd_valid) ok = 1'b0;
    end
    chk("t2 glitch", ok, 1);

    // 5: back-to-back transfers with ready held
    cmd_ready = 1'b1;
    exp_q.push_back(2'b01);
    sw_raw[1] = 1'b1;
    step(4);
    exp_q.push_back(2'b10);
    sw_raw[2] = 1'b1;
    cnt = 0;
    for (int i = 0; i < 14; i++) begin
      step(1);
      if (cmd_valid) cnt++;
    end
    chk("t5 valid cycles", cnt, 2);
    chk("t5 dropped", cmd_dropped, 0);
    chk("t5 queue", exp_q.size(), 0);
    sw_raw = '0;
    step(8);

    // table: each switch alone
    for (int v = 0; v < 4; v++) begin
      exp_q.push_back(vecs[v].exp_cmd);
      sw_raw[vecs[v].idx] = 1'b1;
      wait_valid(n);
      chk($sformatf("vec%0d latency", v), n, vecs[v].exp_lat);
      chk($sformatf("vec%0d level", v), sw_level,
          32'(1) << vecs[v].idx);
      step(1);
      chk($sformatf("vec%0d done", v), cmd_valid, 0);
      sw_raw = '0;
      step(8);
    end
    chk("vec dropped", cmd_dropped, 0);
    cmd_ready = 1'b0;

    // 4: POWER_OFF preempts pending CLEAN
    do_reset();
    exp_q.push_back(2'b00);
    sw_raw[2] = 1'b1;
    step(DB + 3);
    chk("t4 clean", {cmd_valid, cmd, cmd_dropped}, 4'b1100);
    sw_raw[0] = 1'b1;
    step(DB + 3);
    chk("t4 preempt", {cmd_valid, cmd, cmd_dropped}, 4'b1001);
    cmd_ready = 1'b1;
    step(1);
    cmd_ready = 1'b0;
    chk("t4 taken", cmd_valid, 0);
    sw_raw = '0;
    step(8);

    // 3: simultaneous POWER_OFF and EVADE
    do_reset();
    exp_q.push_back(2'b00);
    sw_raw = 4'b1001;
    step(DB + 2);
    chk("t3 rise", sw_rise, 4'b1001);
    step(1);
    chk("t3 cmd", {cmd_valid, cmd, cmd_dropped}, 4'b1001);
    cmd_ready = 1'b1;
    step(1);
    chk("t3 taken", cmd_valid, 0);
    step(3);
    chk("t3 no evade", cmd_valid, 0);
    cmd_ready = 1'b0;
    sw_raw = '0;
    step(8);

    // 6: ena freeze, then reset with command pending
    do_reset();
    ena = 1'b0;
    sw_raw[3] = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (i == 3) sw_raw[3] = 1'b0;
      if (i == 5) sw_raw[3] = 1'b1;
      step(1);
      if (sw_level != 0 || sw_rise != 0 || cmd_valid) ok = 1'b0;
    end
    chk("t6 frozen", ok, 1);
    ena = 1'b1;
    wait_valid(n);
    chk("t6 pending", {cmd_valid, cmd}, 3'b111);
    rst_n = 1'b0;
    #1;
    chk("t6 async rst",
        {sw_level, sw_rise, cmd, cmd_valid, cmd_dropped}, 0);
    step(2);
    exp_q.push_back(2'b11);
    rst_n = 1'b1;
    cmd_ready = 1'b1;
    wait_valid(n);
    chk("t6 relatency", n, DB + 3);
    chk("t6 recmd", cmd, 2'b11);
    step(1);
    chk("t6 taken", cmd_valid, 0);
    cmd_ready = 1'b0;
    sw_raw = '0;
    step(4);

    chk("queue empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
